// File: rtl/spart_transmit.sv
// SPART transmit half: one-entry holding register feeding a start/8-data/stop
// serialiser paced by the shared baud-enable pulse.
module spart_transmit #(
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       transmit_baud,
  input  logic       transmit_write_en,
  input  logic [7:0] transmit_write_line,
  output logic       txd,
  output logic       tbr,
  output logic       transmit_busy,
  output logic       transmit_done,
  output logic       transmit_overrun
);

  localparam int FRAME_LEN = 9 + STOP_BITS;
  localparam logic [3:0] LAST_BIT = 4'(FRAME_LEN - 1);

  typedef enum logic {IDLE, SENDING} state_t;

  state_t                 r_state;
  logic [FRAME_LEN-1:0]   r_shift;
  logic [3:0]             r_bit_cnt;
  logic [7:0]             r_hold;
  logic                   r_hold_full;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_overrun;

  logic                   w_frame_end;
  logic                   w_load;
  logic [FRAME_LEN-1:0]   w_frame;

  // A reload at frame end shares the pulse that completes the last stop bit,
  // which is what makes back-to-back frames gapless.
  assign w_frame_end = (r_state == SENDING) && transmit_baud && (r_bit_cnt == LAST_BIT);
  assign w_load      = transmit_baud && r_hold_full && ((r_state == IDLE) || w_frame_end);
  assign w_frame     = {{STOP_BITS{1'b1}}, r_hold, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= transmit_write_en && r_hold_full;
      if (w_load) begin
        r_hold_full <= 1'b0;
      end else if (transmit_write_en && !r_hold_full) begin
        r_hold      <= transmit_write_line;
        r_hold_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_shift   <= '1;
      r_bit_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_frame_end;
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_shift   <= w_frame;
            r_bit_cnt <= '0;
            r_busy    <= 1'b1;
            r_state   <= SENDING;
          end
        end
        SENDING: begin
          if (transmit_baud) begin
            if (w_frame_end) begin
              r_bit_cnt <= '0;
              if (w_load) begin
                r_shift <= w_frame;
              end else begin
                r_shift <= '1;
                r_busy  <= 1'b0;
                r_state <= IDLE;
              end
            end else begin
              r_shift   <= {1'b1, r_shift[FRAME_LEN-1:1]};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
        end
      endcase
    end
  end

  assign txd              = r_shift[0];
  assign tbr              = !r_hold_full;
  assign transmit_busy    = r_busy;
  assign transmit_done    = r_done;
  assign transmit_overrun = r_overrun;

endmodule
